// File: rtl/tcbm_handshake_ctrl_pkg.sv
// tcbm_handshake_ctrl_pkg: shared FSM state encodings and host status codes.
package tcbm_handshake_ctrl_pkg;
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RX_HOLD  = 3'd1;
  localparam logic [2:0] TX_WAIT  = 3'd2;
  localparam logic [2:0] TX_SETUP = 3'd3;
  localparam logic [2:0] WAIT_REL = 3'd4;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
endpackage

// File: rtl/tcbm_handshake_ctrl_sync2.sv
// tcbm_sync2: two-flop synchroniser for asynchronous host inputs with a selectable reset level.
module tcbm_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/tcbm_handshake_ctrl.sv
// tcbm_handshake_ctrl: sequences one TCBM byte transfer between the host bus and the local side,
// with a bounded wait in every state that depends on the host or the local logic.
module tcbm_handshake_ctrl
  import tcbm_handshake_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dav_n,
  input  logic       host_rd,
  output logic       ack_n,
  output logic [1:0] st,
  output logic       data_le,
  output logic       data_oe,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       tx_ready,
  input  logic       tx_valid,
  input  logic [1:0] tx_status,
  output logic       busy,
  output logic       timeout
);
  logic                 dav_s, dav_prev_q, dav_fall;
  logic [2:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 ack_q, ack_d, oe_q, oe_d, le_q, le_d, tmo_q, tmo_d;
  logic                 rxv_q, txr_q, busy_q;
  logic [1:0]           st_q, st_nxt;
  logic                 st_en, counting, hit;

  tcbm_sync2 #(.RESET_VAL(1'b1)) u_dav_sync (
    .clock(clock),
    .reset(reset),
    .d_i  (dav_n),
    .q_o  (dav_s)
  );

  assign dav_fall = dav_prev_q & ~dav_s;
  assign counting = (state_q == RX_HOLD) || (state_q == TX_WAIT) || (state_q == WAIT_REL);
  assign hit      = cnt_q == TIMEOUT_W'(TIMEOUT - 1);

  // Handshake conditions are tested before the timeout so a coincident handshake wins.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    oe_d    = oe_q;
    le_d    = 1'b0;
    tmo_d   = 1'b0;
    st_en   = 1'b0;
    st_nxt  = ST_OK;
    case (state_q)
      IDLE: begin
        ack_d = 1'b1;
        oe_d  = 1'b0;
        if (dav_fall) begin
          state_d = host_rd ? TX_WAIT : RX_HOLD;
          le_d    = ~host_rd;
        end
      end
      RX_HOLD: begin
        if (rx_ready || hit) begin
          st_en   = 1'b1;
          st_nxt  = rx_ready ? ST_OK : ST_TIMEOUT;
          ack_d   = 1'b0;
          state_d = WAIT_REL;
        end
      end
      TX_WAIT: begin
        if (tx_valid) begin
          st_en   = 1'b1;
          st_nxt  = tx_status;
          oe_d    = 1'b1;
          state_d = TX_SETUP;
        end else if (hit) begin
          st_en   = 1'b1;
          st_nxt  = ST_TIMEOUT;
          ack_d   = 1'b0;
          state_d = WAIT_REL;
        end
      end
      TX_SETUP: begin
        ack_d   = 1'b0;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (dav_s || hit) begin
          ack_d   = 1'b1;
          oe_d    = 1'b0;
          tmo_d   = ~dav_s;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || !counting) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dav_prev_q <= 1'b1;
      ack_q      <= 1'b1;
      oe_q       <= 1'b0;
      le_q       <= 1'b0;
      tmo_q      <= 1'b0;
      rxv_q      <= 1'b0;
      txr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dav_prev_q <= dav_s;
      ack_q      <= ack_d;
      oe_q       <= oe_d;
      le_q       <= le_d;
      tmo_q      <= tmo_d;
      rxv_q      <= state_d == RX_HOLD;
      txr_q      <= state_d == TX_WAIT;
      busy_q     <= state_d != IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) st_q <= ST_OK;
    else if (st_en) st_q <= st_nxt;
  end

  assign ack_n    = ack_q;
  assign st       = st_q;
  assign data_le  = le_q;
  assign data_oe  = oe_q;
  assign rx_valid = rxv_q;
  assign tx_ready = txr_q;
  assign busy     = busy_q;
  assign timeout  = tmo_q;
endmodule

// File: tb/tb_tcbm_handshake_ctrl.sv
// tb_tcbm_handshake_ctrl: directed scenarios for the TCBM handshake controller with TIMEOUT=8.
module tb_tcbm_handshake_ctrl;
  logic       clock = 1'b0, reset = 1'b1;
  logic       dav_n = 1'b1, host_rd = 1'b0, rx_ready = 1'b0, tx_valid = 1'b0;
  logic [1:0] tx_status = 2'b00;
  logic       ack_n, data_le, data_oe, rx_valid, tx_ready, busy, timeout;
  logic [1:0] st;
  int vec = 0, miss = 0, le_cnt = 0, tmo_cnt = 0;

  tcbm_handshake_ctrl #(.TIMEOUT_W(16), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .dav_n(dav_n), .host_rd(host_rd),
    .ack_n(ack_n), .st(st), .data_le(data_le), .data_oe(data_oe),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_status(tx_status), .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (data_le) le_cnt++;
      if (timeout) tmo_cnt++;
    end
  endtask

  task automatic settle();
    dav_n = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0; host_rd = 1'b0;
    tick(4);
    le_cnt = 0; tmo_cnt = 0;
  endtask

  task automatic test_reset();
    tick(2);
    vec++; if ({ack_n, st, data_le, data_oe, rx_valid, tx_ready, busy, timeout} !== 9'b1_00_000000) begin
      miss++; $display("FAIL reset outs got %b want 100000000", {ack_n, st, data_le, data_oe, rx_valid, tx_ready, busy, timeout});
    end
    reset = 1'b0;
    settle();
  endtask

  task automatic test_host_write();
    dav_n = 1'b0; host_rd = 1'b0; rx_ready = 1'b1;
    tick(2);
    vec++; if (data_le !== 1'b0) begin miss++; $display("FAIL wr_le_early got %b want 0", data_le); end
    tick(1);
    vec++; if ({data_le, rx_valid, busy} !== 3'b111) begin miss++; $display("FAIL wr_le got %b want 111", {data_le, rx_valid, busy}); end
    tick(1);
    vec++; if ({ack_n, st, data_le, rx_valid} !== 5'b0_00_00) begin miss++; $display("FAIL wr_ack got %b want 00000", {ack_n, st, data_le, rx_valid}); end
    tick(1);
    dav_n = 1'b1;
    tick(2);
    vec++; if (ack_n !== 1'b0) begin miss++; $display("FAIL wr_hold got %b want 0", ack_n); end
    tick(1);
    vec++; if ({ack_n, busy} !== 2'b10) begin miss++; $display("FAIL wr_release got %b want 10", {ack_n, busy}); end
    vec++; if (le_cnt != 1) begin miss++; $display("FAIL wr_le_count got %0d want 1", le_cnt); end
    settle();
  endtask

  task automatic test_host_read();
    tx_valid = 1'b1; tx_status = 2'b11; dav_n = 1'b0; host_rd = 1'b1;
    tick(3);
    vec++; if ({tx_ready, data_oe, ack_n} !== 3'b101) begin miss++; $display("FAIL rd_wait got %b want 101", {tx_ready, data_oe, ack_n}); end
    tick(1);
    vec++; if ({tx_ready, data_oe, ack_n, st} !== 5'b0_1_1_11) begin miss++; $display("FAIL rd_oe got %b want 01111", {tx_ready, data_oe, ack_n, st}); end
    tick(1);
    tx_valid = 1'b0;
    vec++; if ({data_oe, ack_n} !== 2'b10) begin miss++; $display("FAIL rd_ack got %b want 10", {data_oe, ack_n}); end
    dav_n = 1'b1;
    tick(2);
    vec++; if ({data_oe, ack_n} !== 2'b10) begin miss++; $display("FAIL rd_hold got %b want 10", {data_oe, ack_n}); end
    tick(1);
    vec++; if ({data_oe, ack_n, st, le_cnt[0]} !== 5'b0_1_11_0) begin miss++; $display("FAIL rd_release got %b want 01110", {data_oe, ack_n, st, le_cnt[0]}); end
    settle();
  endtask

  task automatic test_tx_timeout();
    dav_n = 1'b0; host_rd = 1'b1;
    tick(10);
    vec++; if ({tx_ready, ack_n} !== 2'b11) begin miss++; $display("FAIL txto_wait got %b want 11", {tx_ready, ack_n}); end
    tick(1);
    vec++; if ({tx_ready, ack_n, st} !== 4'b0_0_10) begin miss++; $display("FAIL txto_err got %b want 0010", {tx_ready, ack_n, st}); end
    dav_n = 1'b1;
    tick(3);
    vec++; if ({ack_n, busy, tmo_cnt[0]} !== 3'b100) begin miss++; $display("FAIL txto_release got %b want 100", {ack_n, busy, tmo_cnt[0]}); end
    settle();
  endtask

  task automatic test_rel_timeout();
    dav_n = 1'b0; host_rd = 1'b0; rx_ready = 1'b1;
    tick(11);
    vec++; if ({ack_n, timeout, busy} !== 3'b001) begin miss++; $display("FAIL relto_pre got %b want 001", {ack_n, timeout, busy}); end
    tick(1);
    vec++; if ({ack_n, timeout, busy, st} !== 5'b1_1_0_00) begin miss++; $display("FAIL relto_fire got %b want 11000", {ack_n, timeout, busy, st}); end
    tick(1);
    vec++; if (timeout !== 1'b0) begin miss++; $display("FAIL relto_pulse got %b want 0", timeout); end
    dav_n = 1'b1;
    tick(4);
    vec++; if ({le_cnt, tmo_cnt, 1'b0} != {32'd1, 32'd1, busy}) begin miss++; $display("FAIL relto_after le=%0d tmo=%0d busy=%b want 1 1 0", le_cnt, tmo_cnt, busy); end
    settle();
  endtask

  task automatic test_reset_mid();
    tx_valid = 1'b1; tx_status = 2'b01; dav_n = 1'b0; host_rd = 1'b1;
    tick(5);
    vec++; if ({ack_n, data_oe, st} !== 4'b0_1_01) begin miss++; $display("FAIL rst_pre got %b want 0101", {ack_n, data_oe, st}); end
    #1 reset = 1'b1;
    #1;
    vec++; if ({ack_n, data_oe, st, busy} !== 5'b1_0_00_0) begin miss++; $display("FAIL rst_async got %b want 10000", {ack_n, data_oe, st, busy}); end
    tx_valid = 1'b0; dav_n = 1'b1;
    tick(2);
    reset = 1'b0;
    settle();
    dav_n = 1'b0; host_rd = 1'b0; rx_ready = 1'b1;
    tick(4);
    vec++; if ({ack_n, st, busy, le_cnt[1:0]} !== 6'b0_00_1_01) begin miss++; $display("FAIL rst_clean got %b want 000101", {ack_n, st, busy, le_cnt[1:0]}); end
    settle();
  endtask

  task automatic test_glitch();
    @(posedge clock);
    #2 dav_n = 1'b0;
    #3 dav_n = 1'b1;
    tick(5);
    vec++; if ({busy, le_cnt[0]} !== 2'b00) begin miss++; $display("FAIL glitch got %b want 00", {busy, le_cnt[0]}); end
    dav_n = 1'b0; host_rd = 1'b0; rx_ready = 1'b0;
    tick(3);
    dav_n = 1'b1;
    tick(2);
    dav_n = 1'b0;
    tick(3);
    vec++; if ({rx_valid, ack_n, busy, le_cnt[1:0]} !== 5'b1_1_1_01) begin miss++; $display("FAIL toggle_rx got %b want 11101", {rx_valid, ack_n, busy, le_cnt[1:0]}); end
    rx_ready = 1'b1;
    tick(1);
    vec++; if ({ack_n, st} !== 3'b0_00) begin miss++; $display("FAIL toggle_ack got %b want 000", {ack_n, st}); end
    dav_n = 1'b1;
    tick(3);
    vec++; if ({ack_n, busy} !== 2'b10) begin miss++; $display("FAIL toggle_rel got %b want 10", {ack_n, busy}); end
    settle();
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_host_read();
    test_tx_timeout();
    test_rel_timeout();
    test_reset_mid();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
